// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding, parity helper.
// Optional PARITY state exists only when UART_OUTPUT_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_OUTPUT_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

  function automatic logic parity_of(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_output_if.sv
// Byte-stream handshake plus serial line of the UART transmitter.
interface uart_output_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 txd;
  logic                 busy;

  modport master (
    output data,
    output valid,
    input  ready,
    input  txd,
    input  busy
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    output txd,
    output busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1, tick is high for the final count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int         W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_output.sv
// UART transmitter: 8N1 frames, or 8-bit + parity + stop when
// UART_OUTPUT_PARITY_EN is defined. txd, ready are registered.
module uart_output
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_idx;
  logic                 r_txd;
  logic                 r_ready;
  logic                 w_tick;
  logic                 w_clear;

  // Timer held at zero while idle so the start bit gets a full period.
  assign w_clear = (r_state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  assign ready = r_ready;
  assign busy  = ~r_ready;
  assign txd   = r_txd;

`ifdef UART_OUTPUT_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (r_state == IDLE && valid && r_ready) begin
      r_par <= parity_of(data, PARITY_ODD);
    end
  end
`else
  logic w_unused_parity;
  assign w_unused_parity = PARITY_ODD;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid && r_ready) begin
            r_shift <= data;
            r_idx   <= '0;
            r_txd   <= 1'b0;
            r_ready <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_BIT) begin
`ifdef UART_OUTPUT_PARITY_EN
              r_txd   <= r_par;
              r_state <= PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
`ifdef UART_OUTPUT_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_txd   <= 1'b1;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_output.sv
// Bench for uart_output at CLKS_PER_BIT=4: table-driven frames checked
// through a scoreboard queue, plus back-to-back and mid-frame reset sequences.
module tb_uart_output;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_OUTPUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_output_if bus();

  uart_output #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .data (bus.data),
    .valid(bus.valid),
    .ready(bus.ready),
    .txd  (bus.txd),
    .busy (bus.busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       par;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [7:0] mid;
    logic       par;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] mid,
                      input logic par, input bit hold);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      check("send_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.data  = d;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{d: d, par: par, acc: cyc});
    bus.data = mid;
    if (!hold) bus.valid = 1'b0;
  endtask

  task automatic mon_frame(output int acc);
    exp_t            e;
    logic [NB-1:0]   bits;
    int              n = 0;
    int              bad;
    int              rbad = 0;
    acc = -1;
    @(negedge clk);
    while (bus.txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.txd !== 1'b0 || sb.size() == 0) begin
      check("start_seen", {31'd0, bus.txd}, 32'd0);
      return;
    end
    e   = sb.pop_front();
    acc = e.acc;
    check($sformatf("start_lat_%h", e.d), cyc - e.acc, 0);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
`ifdef UART_OUTPUT_PARITY_EN
    bits[9] = e.par;
`endif
    bits[NB-1] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (bus.txd !== bits[b]) bad++;
        if (bus.ready !== 1'b0) rbad++;
      end
      check($sformatf("bit%0d_%h", b, e.d), bad, 0);
    end
    check($sformatf("ready_low_%h", e.d), rbad, 0);
    @(negedge clk);
    check($sformatf("ready_lat_%h", e.d),
          (bus.ready === 1'b1) ? cyc - e.acc : -1, FRAME);
    check($sformatf("busy_idle_%h", e.d), {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, r0, acc;
    logic [7:0] dd;

    vt[0] = '{d: 8'h55, mid: 8'h55, par: 1'b0};
    vt[1] = '{d: 8'h07, mid: 8'h07, par: 1'b1};
    vt[2] = '{d: 8'h00, mid: 8'hFF, par: 1'b0};
    vt[3] = '{d: 8'h81, mid: 8'h81, par: 1'b0};
    vt[4] = '{d: 8'hFF, mid: 8'h00, par: 1'b0};
    vt[5] = '{d: 8'h01, mid: 8'h01, par: 1'b1};

    bus.valid = 1'b0;
    bus.data  = 8'h00;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd",   {31'd0, bus.txd},   32'd1);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fork
        send(vt[i].d, vt[i].mid, vt[i].par, 1'b0);
        mon_frame(acc);
      join
    end

    fork
      begin
        send(8'hA5, 8'h3C, 1'b0, 1'b1);
        send(8'h3C, 8'h3C, 1'b0, 1'b0);
      end
      begin
        mon_frame(a1);
        mon_frame(a2);
      end
    join
    check("b2b_gap", a2 - a1, FRAME + 1);

    @(negedge clk);
    send(8'hC3, 8'hC3, 1'b0, 1'b0);
    acc = sb[sb.size()-1].acc;
    n_chk = n_chk;
    while (cyc < acc + 17) @(negedge clk);
    dd = 8'hC3;
    check("pre_rst_bit3", {31'd0, bus.txd}, {31'd0, dd[3]});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txd",   {31'd0, bus.txd},   32'd1);
    check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    check("mid_rst_busy",  {31'd0, bus.busy},  32'd0);
    sb.delete();
    repeat (2) @(negedge clk);

    fork
      begin
        r0        = cyc;
        rst       = 1'b0;
        bus.data  = 8'h81;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{d: 8'h81, par: 1'b0, acc: cyc});
        bus.valid = 1'b0;
      end
      mon_frame(a1);
    join
    check("accept_after_rst", a1, r0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
